// File: rtl/move_input_ctrl.sv
// Input stage for the connect-four game FSM: synchronizes and debounces the drop
// button and column switches, then hands one validated move per press to the game.
module move_input_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic [6:0] sw_in,
    input  logic       q_p1,
    input  logic       q_p2,
    input  logic       q_end,
    output logic [6:0] player_input,
    output logic       start,
    output logic       player,
    output logic       bad_sel,
    output logic       busy,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        ISSUE    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic       btn_s1, btn_s2;
    logic [6:0] sw_s1, sw_s2;
    logic [CNT_W-1:0] db_cnt;
    logic       db_btn, db_btn_d;
    logic       press;
    logic       sel_one_hot;
    logic       latch_sel;
    logic       bad_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_in;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
        end
    end

    // The counter tracks how long the synchronized button has sat at a level other
    // than db_btn; any return to the accepted level (a bounce) starts it over.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt   <= '0;
            db_btn   <= 1'b0;
            db_btn_d <= 1'b0;
        end else begin
            db_btn_d <= db_btn;
            if (btn_s2 == db_btn) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_TOP) begin
                db_btn <= btn_s2;
                db_cnt <= '0;
            end else if (db_cnt != CNT_MAX) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press       = db_btn & ~db_btn_d;
    assign sel_one_hot = (sw_s2 != 7'd0) && ((sw_s2 & (sw_s2 - 7'd1)) == 7'd0);

    always_comb begin
        state_nxt = state;
        latch_sel = 1'b0;
        bad_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    if (sel_one_hot) begin
                        latch_sel = 1'b1;
                        state_nxt = PEND;
                    end else begin
                        bad_nxt   = 1'b1;
                        state_nxt = WAIT_REL;
                    end
                end
            end
            PEND: begin
                if (q_end)              state_nxt = WAIT_REL;
                else if (q_p1 || q_p2)  state_nxt = ISSUE;
            end
            // q_end here is unexpected; both-low covers it and we exit cleanly.
            ISSUE: begin
                if (!q_p1 && !q_p2) state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (!db_btn) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bad_sel      <= 1'b0;
            player_input <= '0;
            player       <= 1'b0;
        end else begin
            state   <= state_nxt;
            bad_sel <= bad_nxt;
            if (latch_sel) player_input <= sw_s2;
            if (q_p1)      player <= 1'b0;
            else if (q_p2) player <= 1'b1;
        end
    end

    assign start     = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl: a small game-FSM model answers start, and a
// monitor checks every start / bad_sel episode against an expected-event queue.
module tb_move_input_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic [6:0] sw_in;
    logic       q_p1 = 1'b0;
    logic       q_p2 = 1'b0;
    logic       q_end = 1'b0;
    logic [6:0] player_input;
    logic       start;
    logic       player;
    logic       bad_sel;
    logic       busy;
    logic [1:0] fsm_state;

    move_input_ctrl #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .sw_in(sw_in),
        .q_p1(q_p1), .q_p2(q_p2), .q_end(q_end),
        .player_input(player_input), .start(start), .player(player),
        .bad_sel(bad_sel), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // event record: {kind[1:0], player_input[6:0], player, length[3:0]}
    logic [13:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Game FSM model: want selects P1(1)/P2(2)/END(3)/none(0). It sees start at
    // one edge and leaves its input state right after that edge.
    int want = 0;
    int want_prev = 0;
    bit left_st = 1'b0;
    bit start_prev = 1'b0;

    always @(negedge clk) begin
        if (want != want_prev) left_st = 1'b0;
        want_prev = want;
        if (start_prev && (q_p1 || q_p2)) left_st = 1'b1;
        start_prev = start;
        q_p1  = (want == 1) && !left_st;
        q_p2  = (want == 2) && !left_st;
        q_end = (want == 3);
    end

    function automatic logic [13:0] ev(input logic [1:0] kind, input logic [6:0] pin,
                                       input logic pl, input logic [3:0] len);
        return {kind, pin, pl, len};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic emit(input logic [13:0] got);
        logic [13:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event_unexpected: got %h expected none", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL event: got %h expected %h", got, e);
            end
        end
    endtask

    int st_len = 0;
    int bs_len = 0;
    logic [6:0] st_pin, bs_pin;
    logic       st_pl, bs_pl;

    always @(negedge clk) begin
        if (start === 1'b1) begin
            if (st_len == 0) begin
                st_pin = player_input;
                st_pl  = player;
            end
            st_len++;
        end else if (st_len != 0) begin
            emit(ev(2'd1, st_pin, st_pl, 4'(st_len)));
            st_len = 0;
        end
        if (bad_sel === 1'b1) begin
            if (bs_len == 0) begin
                bs_pin = player_input;
                bs_pl  = player;
            end
            bs_len++;
        end else if (bs_len != 0) begin
            emit(ev(2'd2, bs_pin, bs_pl, 4'(bs_len)));
            bs_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bounce();
        for (int i = 0; i < 3; i++) begin
            btn_in = 1'b1;
            tick();
            btn_in = 1'b0;
            tick();
        end
        btn_in = 1'b1;
    endtask

    task automatic press_btn(input int hold);
        bounce();
        repeat (hold) tick();
    endtask

    task automatic release_btn();
        btn_in = 1'b0;
        repeat (14) tick();
    endtask

    bit found;

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        sw_in  = 7'd0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_player_input", player_input, 0);
        check("rst_player", player, 0);
        check("rst_bad_sel", bad_sel, 0);
        check("rst_state", fsm_state, 0);
        tick();
        reset = 1'b0;

        // bounced press while game waits in P1
        want  = 1;
        sw_in = 7'b0001000;
        repeat (3) tick();
        exp_q.push_back(ev(2'd1, 7'b0001000, 1'b0, 4'd2));
        press_btn(14);
        release_btn();
        @(negedge clk);
        check("t1_player_input", player_input, 7'b0001000);
        check("t1_player", player, 0);
        check("t1_busy", busy, 0);

        // two bits set: bad_sel pulse, no move
        sw_in = 7'b0011000;
        repeat (3) tick();
        exp_q.push_back(ev(2'd2, 7'b0001000, 1'b0, 4'd1));
        press_btn(12);
        @(negedge clk);
        check("t2_state_wait_rel", fsm_state, 3);
        check("t2_busy", busy, 1);
        check("t2_start", start, 0);
        release_btn();
        @(negedge clk);
        check("t2_state_idle", fsm_state, 0);
        check("t2_busy_after", busy, 0);
        check("t2_player_input", player_input, 7'b0001000);

        // deferred: no input state yet, then P2 arrives
        want  = 0;
        sw_in = 7'b1000000;
        repeat (3) tick();
        press_btn(12);
        @(negedge clk);
        check("t3_state_pend", fsm_state, 1);
        check("t3_player_before", player, 0);
        check("t3_start_pend", start, 0);
        repeat (10) tick();
        exp_q.push_back(ev(2'd1, 7'b1000000, 1'b1, 4'd2));
        want = 2;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t3_start", start, 1);
        check("t3_player", player, 1);
        check("t3_player_input", player_input, 7'b1000000);
        tick();
        release_btn();
        @(negedge clk);
        check("t3_busy_after", busy, 0);

        // game at END: move latched but discarded
        want  = 3;
        sw_in = 7'b0000100;
        repeat (3) tick();
        press_btn(12);
        @(negedge clk);
        check("t4_state_wait_rel", fsm_state, 3);
        check("t4_start", start, 0);
        check("t4_busy", busy, 1);
        release_btn();
        @(negedge clk);
        check("t4_busy_after", busy, 0);
        check("t4_player_input", player_input, 7'b0000100);

        // held button across two input-state visits: one move only
        want  = 1;
        sw_in = 7'b0100000;
        repeat (3) tick();
        exp_q.push_back(ev(2'd1, 7'b0100000, 1'b0, 4'd2));
        press_btn(40);
        want = 2;
        repeat (60) tick();
        @(negedge clk);
        check("t5_state_held", fsm_state, 3);
        check("t5_player", player, 1);
        release_btn();
        @(negedge clk);
        check("t5_busy_after", busy, 0);

        // reset while start is high
        sw_in = 7'b0000010;
        repeat (3) tick();
        exp_q.push_back(ev(2'd1, 7'b0000010, 1'b1, 4'd1));
        bounce();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (start === 1'b1) found = 1'b1;
        end
        check("t6_start_seen", found, 1);
        reset  = 1'b1;
        btn_in = 1'b0;
        @(negedge clk);
        check("t6_start", start, 0);
        check("t6_busy", busy, 0);
        check("t6_player_input", player_input, 0);
        check("t6_player", player, 0);
        check("t6_state", fsm_state, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
